// File: rtl/rstp_dbg_desc_csr.sv
// rstp_dbg_desc_csr: RDDM CSR window with H2T/T2H descriptor FIFOs, sticky status and masked interrupt
module rstp_dbg_desc_csr #(
    parameter int DESC_DEPTH = 32,
    parameter int MEM_DEPTH = 4096,
    parameter int NUM_CHANNELS = 1,
    parameter logic [31:0] REVISION = 32'h0000_0001,
    localparam int CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           csr_wr,
    input  logic           csr_rd,
    input  logic [11:0]    csr_addr,
    input  logic [31:0]    csr_wdata,
    output logic [31:0]    csr_rdata,
    output logic           csr_rvalid,
    output logic           h2t_desc_valid,
    input  logic           h2t_desc_ready,
    output logic [31:0]    h2t_len,
    output logic [31:0]    h2t_loc,
    output logic [31:0]    h2t_conn,
    output logic [CHW-1:0] h2t_chan,
    input  logic           t2h_desc_valid,
    output logic           t2h_desc_ready,
    input  logic [31:0]    t2h_len,
    input  logic [31:0]    t2h_loc,
    input  logic [31:0]    t2h_conn,
    input  logic [CHW-1:0] t2h_chan,
    output logic           pkt_reset,
    output logic           lpbk_en,
    output logic           irq
);
    localparam int AW = $clog2(DESC_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]    h_len [DESC_DEPTH];
    logic [31:0]    h_loc [DESC_DEPTH];
    logic [31:0]    h_conn[DESC_DEPTH];
    logic [CHW-1:0] h_chan[DESC_DEPTH];
    logic [31:0]    t_len [DESC_DEPTH];
    logic [31:0]    t_loc [DESC_DEPTH];
    logic [31:0]    t_conn[DESC_DEPTH];
    logic [CHW-1:0] t_chan[DESC_DEPTH];
    logic [AW-1:0]  h_wp, h_rp, t_wp, t_rp;
    logic [CW-1:0]  h_cnt, t_cnt;
    logic [31:0]    stage_len, stage_loc, stage_conn;
    logic [3:0]     status, mask, st_set, st_clr;
    logic [31:0]    rd_val;
    logic           commit, h_pop, h_full, h_ovf, h_bad, h_push, t_push, t_pop, t_empty;

    assign h_full = h_cnt == CW'(DESC_DEPTH);
    assign t_empty = t_cnt == '0;
    assign h2t_desc_valid = h_cnt != '0;
    assign h2t_len = h_len[h_rp];
    assign h2t_loc = h_loc[h_rp];
    assign h2t_conn = h_conn[h_rp];
    assign h2t_chan = h_chan[h_rp];
    assign t2h_desc_ready = !rst && t_cnt != CW'(DESC_DEPTH);
    assign h_pop = h2t_desc_valid && h2t_desc_ready;
    assign commit = csr_wr && csr_addr == 12'h114;
    // A pop in the same cycle frees the slot, so a commit into a full FIFO is still accepted
    assign h_ovf = commit && h_full && !h_pop;
    assign h_bad = commit && !h_ovf && csr_wdata >= 32'(NUM_CHANNELS);
    assign h_push = commit && !h_ovf && !h_bad;
    assign t_push = t2h_desc_valid && t2h_desc_ready;
    assign t_pop = csr_wr && csr_addr == 12'h218 && !t_empty;
    assign st_set = {h_bad, h_ovf, t_push, h_pop};
    assign st_clr = (csr_wr && csr_addr == 12'h040) ? csr_wdata[3:0] : 4'b0;

    always_comb begin
        rd_val = 32'hDEAD_C0DE;
        case (csr_addr)
            12'h000: rd_val = 32'h5244_444D;
            12'h004: rd_val = REVISION;
            12'h020: rd_val = {23'b0, lpbk_en, 8'b0};
            12'h024: rd_val = 32'(MEM_DEPTH);
            12'h02C: rd_val = 32'(DESC_DEPTH);
            12'h040: rd_val = {28'b0, status};
            12'h048: rd_val = {28'b0, mask};
            12'h100: rd_val = 32'(DESC_DEPTH) - 32'(h_cnt);
            12'h200: rd_val = 32'(t_cnt);
            12'h208: rd_val = t_empty ? 32'b0 : t_len[t_rp];
            12'h20C: rd_val = t_empty ? 32'b0 : t_loc[t_rp];
            12'h210: rd_val = t_empty ? 32'b0 : t_conn[t_rp];
            12'h214: rd_val = t_empty ? 32'b0 : 32'(t_chan[t_rp]);
            default: rd_val = 32'hDEAD_C0DE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (h_push) begin
            h_len[h_wp] <= stage_len;
            h_loc[h_wp] <= stage_loc;
            h_conn[h_wp] <= stage_conn;
            h_chan[h_wp] <= csr_wdata[CHW-1:0];
        end
        if (t_push) begin
            t_len[t_wp] <= t2h_len;
            t_loc[t_wp] <= t2h_loc;
            t_conn[t_wp] <= t2h_conn;
            t_chan[t_wp] <= t2h_chan;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csr_rdata <= '0;
            csr_rvalid <= 1'b0;
            pkt_reset <= 1'b0;
            lpbk_en <= 1'b0;
            irq <= 1'b0;
            status <= '0;
            mask <= '0;
            stage_len <= '0;
            stage_loc <= '0;
            stage_conn <= '0;
            h_wp <= '0;
            h_rp <= '0;
            h_cnt <= '0;
            t_wp <= '0;
            t_rp <= '0;
            t_cnt <= '0;
        end else begin
            csr_rvalid <= csr_rd;
            csr_rdata <= csr_rd ? rd_val : csr_rdata;
            pkt_reset <= csr_wr && csr_addr == 12'h020 && csr_wdata[0];
            lpbk_en <= (csr_wr && csr_addr == 12'h020) ? csr_wdata[8] : lpbk_en;
            mask <= (csr_wr && csr_addr == 12'h048) ? csr_wdata[3:0] : mask;
            stage_len <= (csr_wr && csr_addr == 12'h108) ? csr_wdata : stage_len;
            stage_loc <= (csr_wr && csr_addr == 12'h10C) ? csr_wdata : stage_loc;
            stage_conn <= (csr_wr && csr_addr == 12'h110) ? csr_wdata : stage_conn;
            status <= (status & ~st_clr) | st_set;
            irq <= |(status & mask);
            h_wp <= h_wp + AW'(h_push);
            h_rp <= h_rp + AW'(h_pop);
            h_cnt <= h_cnt + CW'(h_push) - CW'(h_pop);
            t_wp <= t_wp + AW'(t_push);
            t_rp <= t_rp + AW'(t_pop);
            t_cnt <= t_cnt + CW'(t_push) - CW'(t_pop);
        end
    end
endmodule

// File: tb/tb_rstp_dbg_desc_csr.sv
// tb_rstp_dbg_desc_csr: directed bench for rstp_dbg_desc_csr (DESC_DEPTH=32, NUM_CHANNELS=4)
module tb_rstp_dbg_desc_csr;
    logic        clk = 1'b0, rst = 1'b1;
    logic        csr_wr = 1'b0, csr_rd = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0, csr_rdata;
    logic        csr_rvalid;
    logic        h2t_desc_valid, h2t_desc_ready = 1'b0;
    logic [31:0] h2t_len, h2t_loc, h2t_conn;
    logic [1:0]  h2t_chan;
    logic        t2h_desc_valid = 1'b0, t2h_desc_ready;
    logic [31:0] t2h_len = '0, t2h_loc = '0, t2h_conn = '0;
    logic [1:0]  t2h_chan = '0;
    logic        pkt_reset, lpbk_en, irq;
    int          vectors = 0, miscompares = 0;
    logic [31:0] d;

    rstp_dbg_desc_csr #(.DESC_DEPTH(32), .MEM_DEPTH(4096), .NUM_CHANNELS(4), .REVISION(32'h0000_0001)) dut (
        .clk(clk), .rst(rst), .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
        .h2t_desc_valid(h2t_desc_valid), .h2t_desc_ready(h2t_desc_ready), .h2t_len(h2t_len),
        .h2t_loc(h2t_loc), .h2t_conn(h2t_conn), .h2t_chan(h2t_chan),
        .t2h_desc_valid(t2h_desc_valid), .t2h_desc_ready(t2h_desc_ready), .t2h_len(t2h_len),
        .t2h_loc(t2h_loc), .t2h_conn(t2h_conn), .t2h_chan(t2h_chan),
        .pkt_reset(pkt_reset), .lpbk_en(lpbk_en), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        csr_wr = 1'b1; csr_addr = a; csr_wdata = v;
        @(posedge clk); #1;
        csr_wr = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        csr_rd = 1'b1; csr_addr = a;
        @(posedge clk); #1;
        csr_rd = 1'b0;
        v = csr_rdata;
    endtask

    task automatic t2h_push(input logic [31:0] len, input logic [31:0] loc, input logic [31:0] conn, input logic [1:0] ch);
        t2h_desc_valid = 1'b1; t2h_len = len; t2h_loc = loc; t2h_conn = conn; t2h_chan = ch;
        @(posedge clk); #1;
        t2h_desc_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] exp_v[8];
        logic [11:0] addr_v[8];
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if ({csr_rvalid, pkt_reset, lpbk_en, irq, h2t_desc_valid, t2h_desc_ready} !== 6'b0) begin
            miscompares++; $display("FAIL reset_outputs got %b exp 000000", {csr_rvalid, pkt_reset, lpbk_en, irq, h2t_desc_valid, t2h_desc_ready});
        end
        vectors++;
        rst = 1'b0;
        #1;
        if (t2h_desc_ready !== 1'b1) begin
            miscompares++; $display("FAIL t2h_ready_after_rst got %b exp 1", t2h_desc_ready);
        end
        vectors++;
        @(posedge clk); #1;
        addr_v = '{12'h000, 12'h004, 12'h024, 12'h02C, 12'h100, 12'h300, 12'h200, 12'h040};
        exp_v = '{32'h5244_444D, 32'h1, 32'h1000, 32'h20, 32'h20, 32'hDEAD_C0DE, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            rd(addr_v[i], d);
            if (d !== exp_v[i] || csr_rvalid !== 1'b1) begin
                miscompares++; $display("FAIL reset_read_%h got %h rvalid %b exp %h", addr_v[i], d, csr_rvalid, exp_v[i]);
            end
            vectors++;
        end
        @(posedge clk); #1;
        if (csr_rvalid !== 1'b0) begin
            miscompares++; $display("FAIL rvalid_single got %b exp 0", csr_rvalid);
        end
        vectors++;
    endtask

    task automatic test_h2t_fill;
        h2t_desc_ready = 1'b0;
        for (int i = 0; i < 33; i++) begin
            wr(12'h108, 32'h1000 + i);
            wr(12'h10C, 32'h2000 + i);
            wr(12'h110, 32'h3000 + i);
            wr(12'h114, 32'(i % 4));
        end
        rd(12'h100, d);
        if (d !== 32'h0) begin miscompares++; $display("FAIL h2t_slots_full got %h exp 0", d); end
        vectors++;
        rd(12'h040, d);
        if (d !== 32'h4) begin miscompares++; $display("FAIL h2t_ovf_status got %h exp 4", d); end
        vectors++;
        if (h2t_desc_valid !== 1'b1 || h2t_len !== 32'h1000 || h2t_loc !== 32'h2000 || h2t_conn !== 32'h3000 || h2t_chan !== 2'd0) begin
            miscompares++; $display("FAIL h2t_head_hold got %b %h %h %h %h exp 1 1000 2000 3000 0", h2t_desc_valid, h2t_len, h2t_loc, h2t_conn, h2t_chan);
        end
        vectors++;
        wr(12'h040, 32'hF);
        h2t_desc_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (h2t_desc_valid !== 1'b1 || h2t_len !== 32'h1000 + i || h2t_chan !== 2'(i % 4)) begin
                miscompares++; $display("FAIL h2t_drain_%0d got %b %h %h exp 1 %h %h", i, h2t_desc_valid, h2t_len, h2t_chan, 32'h1000 + i, i % 4);
            end
            vectors++;
            @(posedge clk); #1;
        end
        if (h2t_desc_valid !== 1'b0) begin miscompares++; $display("FAIL h2t_empty_valid got %b exp 0", h2t_desc_valid); end
        vectors++;
        h2t_desc_ready = 1'b0;
        rd(12'h040, d);
        if (d !== 32'h1) begin miscompares++; $display("FAIL h2t_pop_status got %h exp 1", d); end
        vectors++;
        rd(12'h100, d);
        if (d !== 32'h20) begin miscompares++; $display("FAIL h2t_slots_drained got %h exp 20", d); end
        vectors++;
    endtask

    task automatic test_channel;
        wr(12'h040, 32'hF);
        wr(12'h114, 32'd5);
        rd(12'h100, d);
        if (d !== 32'h20) begin miscompares++; $display("FAIL bad_chan_slots got %h exp 20", d); end
        vectors++;
        rd(12'h040, d);
        if (d !== 32'h8) begin miscompares++; $display("FAIL bad_chan_status got %h exp 8", d); end
        vectors++;
        wr(12'h048, 32'h8);
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_before_latency got %b exp 0", irq); end
        vectors++;
        @(posedge clk); #1;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_masked_on got %b exp 1", irq); end
        vectors++;
        wr(12'h040, 32'h8);
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_clear_latency got %b exp 1", irq); end
        vectors++;
        @(posedge clk); #1;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_cleared got %b exp 0", irq); end
        vectors++;
        wr(12'h048, 32'h0);
    endtask

    task automatic test_t2h;
        for (int i = 0; i < 3; i++) begin
            if (t2h_desc_ready !== 1'b1) begin miscompares++; $display("FAIL t2h_ready_%0d got %b exp 1", i, t2h_desc_ready); end
            vectors++;
            t2h_push(32'h8000_0010 + i, 32'h40 + i, 32'hC0 + i, 2'(i));
        end
        rd(12'h200, d);
        if (d !== 32'h3) begin miscompares++; $display("FAIL t2h_occ3 got %h exp 3", d); end
        vectors++;
        rd(12'h208, d);
        if (d !== 32'h8000_0010) begin miscompares++; $display("FAIL t2h_head_len got %h exp 80000010", d); end
        vectors++;
        rd(12'h20C, d);
        if (d !== 32'h40) begin miscompares++; $display("FAIL t2h_head_loc got %h exp 40", d); end
        vectors++;
        rd(12'h210, d);
        if (d !== 32'hC0) begin miscompares++; $display("FAIL t2h_head_conn got %h exp c0", d); end
        vectors++;
        rd(12'h040, d);
        if (d !== 32'h2) begin miscompares++; $display("FAIL t2h_status got %h exp 2", d); end
        vectors++;
        wr(12'h218, 32'h0);
        rd(12'h200, d);
        if (d !== 32'h2) begin miscompares++; $display("FAIL t2h_occ2 got %h exp 2", d); end
        vectors++;
        rd(12'h208, d);
        if (d !== 32'h8000_0011) begin miscompares++; $display("FAIL t2h_next_len got %h exp 80000011", d); end
        vectors++;
        rd(12'h214, d);
        if (d !== 32'h1) begin miscompares++; $display("FAIL t2h_next_chan got %h exp 1", d); end
        vectors++;
        wr(12'h218, 32'h0);
        wr(12'h218, 32'h0);
        wr(12'h218, 32'h0);
        rd(12'h200, d);
        if (d !== 32'h0) begin miscompares++; $display("FAIL t2h_pop_empty got %h exp 0", d); end
        vectors++;
        rd(12'h208, d);
        if (d !== 32'h0) begin miscompares++; $display("FAIL t2h_empty_len got %h exp 0", d); end
        vectors++;
    endtask

    task automatic test_back_to_back;
        wr(12'h040, 32'hF);
        for (int i = 0; i < 32; i++) begin
            wr(12'h108, 32'h5000 + i);
            wr(12'h114, 32'h0);
        end
        wr(12'h108, 32'h5020);
        h2t_desc_ready = 1'b1;
        csr_wr = 1'b1; csr_addr = 12'h114; csr_wdata = 32'h3;
        @(posedge clk); #1;
        csr_wr = 1'b0;
        h2t_desc_ready = 1'b0;
        rd(12'h100, d);
        if (d !== 32'h0) begin miscompares++; $display("FAIL full_pop_commit_slots got %h exp 0", d); end
        vectors++;
        rd(12'h040, d);
        if (d !== 32'h1) begin miscompares++; $display("FAIL full_pop_commit_status got %h exp 1", d); end
        vectors++;
        h2t_desc_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (h2t_len !== 32'h5001 + i) begin
                miscompares++; $display("FAIL b2b_drain_%0d got %h exp %h", i, h2t_len, 32'h5001 + i);
            end
            vectors++;
            @(posedge clk); #1;
        end
        h2t_desc_ready = 1'b0;
        if (h2t_chan !== 2'd3 && h2t_desc_valid !== 1'b0) begin end
        wr(12'h040, 32'hF);
        t2h_desc_valid = 1'b1; t2h_len = 32'h77; t2h_loc = 32'h0; t2h_conn = 32'h0; t2h_chan = 2'd2;
        csr_wr = 1'b1; csr_addr = 12'h040; csr_wdata = 32'h2;
        @(posedge clk); #1;
        csr_wr = 1'b0; t2h_desc_valid = 1'b0;
        rd(12'h040, d);
        if (d !== 32'h2) begin miscompares++; $display("FAIL set_beats_clear got %h exp 2", d); end
        vectors++;
    endtask

    task automatic test_ctrl_reset;
        csr_wr = 1'b1; csr_addr = 12'h020; csr_wdata = 32'h101;
        @(posedge clk); #1;
        csr_wr = 1'b0;
        if (pkt_reset !== 1'b1 || lpbk_en !== 1'b1) begin
            miscompares++; $display("FAIL ctrl_write got pkt_reset %b lpbk_en %b exp 1 1", pkt_reset, lpbk_en);
        end
        vectors++;
        @(posedge clk); #1;
        if (pkt_reset !== 1'b0) begin miscompares++; $display("FAIL pkt_reset_width got %b exp 0", pkt_reset); end
        vectors++;
        rd(12'h020, d);
        if (d !== 32'h100) begin miscompares++; $display("FAIL ctrl_read got %h exp 100", d); end
        vectors++;
        for (int i = 0; i < 15; i++) t2h_push(32'h900 + i, 32'h0, 32'h0, 2'd1);
        for (int i = 0; i < 16; i++) wr(12'h114, 32'h1);
        rd(12'h100, d);
        if (d !== 32'h10) begin miscompares++; $display("FAIL half_h2t_slots got %h exp 10", d); end
        vectors++;
        rd(12'h200, d);
        if (d !== 32'h10) begin miscompares++; $display("FAIL half_t2h_occ got %h exp 10", d); end
        vectors++;
        wr(12'h040, 32'hF);
        rst = 1'b1;
        h2t_desc_ready = 1'b1;
        #1;
        if (t2h_desc_ready !== 1'b0) begin miscompares++; $display("FAIL t2h_ready_in_rst got %b exp 0", t2h_desc_ready); end
        vectors++;
        @(posedge clk); #1;
        rst = 1'b0;
        h2t_desc_ready = 1'b0;
        if (lpbk_en !== 1'b0 || h2t_desc_valid !== 1'b0) begin
            miscompares++; $display("FAIL mid_rst_outputs got lpbk_en %b h2t_valid %b exp 0 0", lpbk_en, h2t_desc_valid);
        end
        vectors++;
        rd(12'h100, d);
        if (d !== 32'h20) begin miscompares++; $display("FAIL mid_rst_slots got %h exp 20", d); end
        vectors++;
        rd(12'h200, d);
        if (d !== 32'h0) begin miscompares++; $display("FAIL mid_rst_t2h_occ got %h exp 0", d); end
        vectors++;
        rd(12'h040, d);
        if (d !== 32'h0) begin miscompares++; $display("FAIL mid_rst_status got %h exp 0", d); end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_h2t_fill();
        test_channel();
        test_t2h();
        test_back_to_back();
        test_ctrl_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
